pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register for the five-stage MIPS datapath. It generalises the fixed-field stage registers into a valid/ready stage with:
- configurable payload width
- a separately-flushable control field
- a two-entry skid buffer, so a stalled consumer never combinationally stalls the producer
- a saturating stall-cycle counter for performance debug

One instance sits between each pair of pipeline stages (D→E, E→M, M→W). The hazard unit drives `flush`.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_entry.sv | 66 ++++++
 rtl/pipe_stage_skid.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared state encoding and default widths for pipe_stage_skid
// Revision : 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned PIPE_CTRL_W = 8;
  localparam int unsigned PIPE_DATA_W = 96;
  localparam int unsigned PIPE_CNT_W  = 16;

  // Encoding equals the number of valid entries held by the stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_entry.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_entry : valid-tagged ctrl/data register with load, unload and clear
// Revision   : 1.0
// ---------------------------------------------------------------------------
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W   = PIPE_CTRL_W,
  parameter int unsigned DATA_W   = PIPE_DATA_W,
  parameter bit          CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_d, valid_q;
  logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
  logic [DATA_W-1:0] data_d,  data_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLR_DATA) begin
        data_d = '0;
      end
    end else if (load) begin
      valid_d = 1'b1;
      ctrl_d  = load_ctrl;
      data_d  = load_data;
    end else if (unload) begin
      // Data is kept so a drained stage still shows its last operands.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_skid : valid/ready pipeline stage with two-entry skid buffer,
//                   flushable control field and saturating stall counter
// Revision        : 1.0
// ---------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W   = PIPE_CTRL_W,
  parameter int unsigned DATA_W   = PIPE_DATA_W,
  parameter bit          CLR_DATA = 1'b0,
  parameter int unsigned CNT_W    = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_d, state_q;
  logic              in_ready_d, in_ready_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  logic              accept, drain, stall;
  logic              main_load, main_unload, skid_load, skid_unload;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_ld_data;

  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid & out_ready;
  assign stall  = main_valid & ~out_ready;

  always_comb begin
    state_d     = state_q;
    main_load   = 1'b0;
    main_unload = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = ST_TWO;
          skid_load = 1'b1;
        end else if (drain) begin
          state_d     = ST_EMPTY;
          main_unload = 1'b1;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d     = ST_ONE;
          main_load   = 1'b1;
          skid_unload = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // The skid entry is only ever valid in TWO, so it doubles as the refill select.
  always_comb begin
    main_ld_ctrl = in_ctrl;
    main_ld_data = in_data;
    if (skid_valid) begin
      main_ld_ctrl = skid_ctrl;
      main_ld_data = skid_data;
    end
  end

  always_comb begin
    in_ready_d  = (state_d != ST_TWO);
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  pipe_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CLR_DATA (CLR_DATA)
  ) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .load      (main_load),
    .unload    (main_unload),
    .load_ctrl (main_ld_ctrl),
    .load_data (main_ld_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  pipe_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CLR_DATA (CLR_DATA)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .load      (skid_load),
    .unload    (skid_unload),
    .load_ctrl (in_ctrl),
    .load_data (in_data),
    .valid     (skid_valid),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid : scoreboard bench for two pipe_stage_skid configurations
// Revision           : 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;

  logic        in_ready0, out_valid0;
  logic [7:0]  out_ctrl0;
  logic [31:0] out_data0;
  logic [3:0]  stall_cnt0;

  logic        in_ready1, out_valid1;
  logic [7:0]  out_ctrl1;
  logic [31:0] out_data1;
  logic [15:0] stall_cnt1;

  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(32), .CLR_DATA(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
    .out_data(out_data0), .stall_cnt(stall_cnt0)
  );

  pipe_stage_skid #(.CTRL_W(8), .DATA_W(32), .CLR_DATA(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
    .out_data(out_data1), .stall_cnt(stall_cnt1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle from just after a rising edge; record beats the stage will take.
  task automatic step(input logic v, input logic [7:0] c, input logic [31:0] d,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    if (v && (in_ready0 === 1'b1) && !fl && rst_n) exp_q.push_back({c, d});
    @(posedge clk);
    #1;
    if (fl || !rst_n) exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid0 === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got ctrl=0x%0h data=0x%0h, expected no beat",
                 out_ctrl0, out_data0);
      end else begin
        mon_e = exp_q.pop_front();
        check("scoreboard", {24'b0, out_ctrl0, out_data0}, {24'b0, mon_e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    step(0, 8'h00, 32'h0, 0, 0);
    step(0, 8'h00, 32'h0, 0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_ctrl",  out_ctrl0,  0);
    check("rst_out_data",  out_data0,  0);
    check("rst_in_ready",  in_ready0,  1);
    check("rst_stall_cnt", stall_cnt0, 0);
    rst_n = 1'b1;

    // Back-to-back stream, one-cycle latency
    for (int i = 1; i <= 4; i++) begin
      step(1, 8'(8'h10 + i), 32'(i), 1, 0);
      check("stream_valid", out_valid0, 1);
      check("stream_data",  out_data0,  64'(i));
      check("stream_ready", in_ready0,  1);
    end
    step(0, 8'h00, 32'h0, 1, 0);
    check("stream_end_valid", out_valid0, 0);
    check("stream_end_ctrl",  out_ctrl0,  0);
    check("stream_stall_cnt", stall_cnt0, 0);

    // Backpressure into TWO, producer holds C
    step(1, 8'hA1, 32'hA, 1, 0);
    step(1, 8'hB1, 32'hB, 0, 0);
    check("bp_in_ready_low", in_ready0,  0);
    check("bp_stall_1",      stall_cnt0, 1);
    check("bp_main_a",       out_data0,  32'hA);
    step(1, 8'hC1, 32'hC, 0, 0);
    step(1, 8'hC1, 32'hC, 0, 0);
    check("bp_stall_3",      stall_cnt0, 3);
    check("bp_stall_3_w16",  stall_cnt1, 3);
    check("bp_hold_a",       out_data0,  32'hA);
    check("bp_still_full",   in_ready0,  0);
    step(1, 8'hC1, 32'hC, 1, 0);
    check("bp_ready_rise",   in_ready0,  1);
    check("bp_main_b",       out_data0,  32'hB);
    step(1, 8'hC1, 32'hC, 1, 0);
    check("bp_main_c",       out_data0,  32'hC);
    step(0, 8'h00, 32'h0, 1, 0);
    check("bp_drained",      out_valid0, 0);
    check("bp_stall_final",  stall_cnt0, 3);

    // Flush while TWO
    step(1, 8'h11, 32'h1111, 0, 0);
    step(1, 8'h22, 32'h2222, 0, 0);
    check("ft_full", in_ready0, 0);
    step(1, 8'hFF, 32'hDEAD, 0, 1);
    check("ft_valid",      out_valid0, 0);
    check("ft_ctrl",       out_ctrl0,  0);
    check("ft_in_ready",   in_ready0,  1);
    check("ft_data_hold",  out_data0,  32'h1111);
    check("ft_data_clr",   out_data1,  0);
    check("ft_valid_clr",  out_valid1, 0);
    check("ft_stall",      stall_cnt0, 5);

    // Flush coincident with accept in ONE
    step(1, 8'h33, 32'h3333, 0, 0);
    step(1, 8'h44, 32'h4444, 0, 1);
    check("fo_valid",     out_valid0, 0);
    check("fo_in_ready",  in_ready0,  1);
    check("fo_data_hold", out_data0,  32'h3333);
    check("fo_data_clr",  out_data1,  0);
    step(0, 8'h00, 32'h0, 1, 0);
    check("fo_no_beat",   out_valid0, 0);

    // Flush together with drain
    step(1, 8'h55, 32'h5555, 1, 0);
    step(0, 8'h00, 32'h0, 1, 1);
    check("fd_valid", out_valid0, 0);
    check("fd_stall", stall_cnt0, 6);

    // Stall counter saturation
    step(1, 8'h66, 32'h6666, 0, 0);
    repeat (20) step(0, 8'h00, 32'h0, 0, 0);
    check("sat_cnt4",   stall_cnt0, 15);
    check("sat_cnt16",  stall_cnt1, 26);
    check("sat_held",   out_data0,  32'h6666);
    step(0, 8'h00, 32'h0, 0, 1);
    check("sat_flush_cnt4",  stall_cnt0, 15);
    check("sat_flush_cnt16", stall_cnt1, 27);
    check("sat_flush_valid", out_valid0, 0);

    // Reset while TWO
    step(1, 8'h77, 32'h7777, 0, 0);
    step(1, 8'h88, 32'h8888, 0, 0);
    check("rt_full", in_ready0, 0);
    rst_n = 1'b0;
    step(0, 8'h00, 32'h0, 0, 0);
    check("rt_valid",    out_valid0, 0);
    check("rt_ctrl",     out_ctrl0,  0);
    check("rt_data",     out_data0,  0);
    check("rt_data_w16", out_data1,  0);
    check("rt_in_ready", in_ready0,  1);
    check("rt_cnt4",     stall_cnt0, 0);
    check("rt_cnt16",    stall_cnt1, 0);
    rst_n = 1'b1;
    step(0, 8'h00, 32'h0, 1, 0);
    check("rt_idle_valid", out_valid0, 0);
    check("queue_empty",   64'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
